dcache_wb_ctrl: RTL and testbench
=================================

// Module: dcache_wb_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and the line memory model.
//  Tags, valid/dirty bits and 128-bit lines are held in registers. Misses run a writeback/refill sequence over the
//  mem_r/mem_w/mem_ready line interface. The CPU stalls while cpu_ready is low.
// PARAMETERS
//  INDEX_WIDTH        3   index bits; 2^3 = 8 lines
//  LINE_OFFSET_WIDTH  2   word-in-line bits; 4 x 32b = 128b line
//  SPACE_OFFSET       2   byte-in-word bits; word accesses only, addr[1:0] ignored
//  ADDR_WIDTH         32  CPU address width; TAG_W = ADDR_WIDTH-INDEX_WIDTH-LINE_OFFSET_WIDTH-SPACE_OFFSET (25)
// PORTS
//  clk          in   1    clock
//  rstn         in   1    asynchronous, active-low reset
//  cpu_req      in   1    access request; held until cpu_ready
//  cpu_we       in   1    1 = store word, 0 = load word
//  cpu_addr     in   32   byte address
//  cpu_wdata    in   32   store data
//  cpu_rdata    out  32   load data, valid when cpu_req && cpu_ready && !cpu_we
//  cpu_ready    out  1    access completes this cycle
//  mem_r        out  1    line read request
//  mem_w        out  1    line write request
//  mem_addr     out  32   line-aligned address, low LINE_OFFSET_WIDTH+SPACE_OFFSET bits = 0
//  mem_w_data   out  128  victim line
//  mem_r_data   in   128  refill line, valid only while mem_ready = 1
//  mem_ready    in   1    one-cycle completion pulse
//  hit_cnt      out  32   hit counter (CACHE_STATS_EN)
//  miss_cnt     out  32   miss counter (CACHE_STATS_EN)
// BEHAVIOUR
//  - Reset: all valid/dirty bits = 0; state = IDLE; cpu_ready = 0; mem_r = mem_w = 0; counters = 0. Line data is not reset.
//  - FSM states: IDLE, WRITEBACK, REFILL.
//  - IDLE, hit (valid && tag match):
//    - cpu_ready = 1 combinationally in the same cycle (zero wait).
//    - Load returns word addr[3:2].
//    - Store writes that word and sets dirty on the clock edge.
//  - IDLE, miss:
//    - Dirty victim -> WRITEBACK, with mem_addr = {victim_tag, index, 4'b0}.
//    - Clean victim -> REFILL.
//    - cpu_ready = 0.
//  - WRITEBACK:
//    - mem_w = !mem_ready; mem_w_data = victim line.
//    - On mem_ready: clear dirty, go to REFILL.
//  - REFILL:
//    - mem_r = !mem_ready; mem_addr = {req_tag, index, 4'b0}.
//    - On mem_ready: capture mem_r_data into the line, set tag and valid, dirty = 0, go to IDLE.
//    - The request then hits in IDLE; a store merges there.
//  - Request deassertion: mem_r/mem_w fall in the mem_ready cycle, so the memory counter restarts cleanly.
//    WRITEBACK->REFILL therefore leaves one idle cycle on the memory bus.
//  - Latch: cpu_addr, cpu_we and cpu_wdata are latched on miss entry. CPU changes during a stall are ignored until return to IDLE.
//  - Latency (memory with 5-count delay): clean miss = 7 cycles from miss to hit cycle. Dirty miss = 14 cycles.
//  - cpu_req low in IDLE: no state change, cpu_ready = 0.
//  - Reset mid-miss: abort immediately; mem_r/mem_w drop; the in-flight line is discarded (all invalid).
//  - Never assert mem_r and mem_w together.
// CONFIGURATION
//  - CACHE_STATS_EN defined:
//    - hit_cnt increments on each IDLE hit that did not follow a refill.
//    - miss_cnt increments on each IDLE miss.
//    - Both counters wrap at 2^32.
//  - CACHE_STATS_EN undefined: hit_cnt and miss_cnt are tied to 0; no counter flops.
// STRUCTURE
//  - cache_pkg: state enum (IDLE/WRITEBACK/REFILL), TAG_W, LINE_W, and address-field slice localparams.
//    Shared with future I-cache and memory-side blocks.
//  - Sub-module dcache_line_array: tag/valid/dirty/data register file with one combinational read port,
//    a word-write port and a line-write port. The FSM stays in dcache_wb_ctrl.
// TESTING
//  1. Reset, then load 0x0000_0040 -> REFILL: mem_r=1, mem_addr=0x40, memory returns 0x...DDDD_CCCC_BBBB_AAAA.
//     cpu_rdata=0xAAAA_AAAA after 7 cycles; miss_cnt=1.
//  2. Load 0x0000_0044 right after test 1 -> hit, cpu_ready in the same cycle, rdata=0xBBBB_BBBB, no memory access.
//  3. Store 0x1234_5678 to 0x48 (hit) -> no memory traffic; line 4 dirty; a later load of 0x48 returns 0x1234_5678.
//  4. Load 0x0000_0240 (same index 4, new tag) -> WRITEBACK: mem_w, addr 0x40, data word2 = 0x1234_5678.
//     Then idle gap, then REFILL at 0x240; total 14 cycles.
//  5. Store miss to 0x84 (clean) -> refill 0x80, then the word merges, dirty=1; mem_w never asserted during this miss.
//  6. Assert rstn=0 in the middle of REFILL -> mem_r=0 asynchronously. After release, load 0x40 misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache definitions: address-field geometry, line sizes and the
// miss-handling state encoding. Intended for reuse by the I-cache and
// memory-side blocks.
package cache_pkg;

    localparam int ADDR_WIDTH        = 32;
    localparam int INDEX_WIDTH       = 3;
    localparam int LINE_OFFSET_WIDTH = 2;
    localparam int SPACE_OFFSET      = 2;
    localparam int TAG_W             = ADDR_WIDTH - INDEX_WIDTH - LINE_OFFSET_WIDTH - SPACE_OFFSET;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 1 << LINE_OFFSET_WIDTH;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
    localparam int NUM_LINES      = 1 << INDEX_WIDTH;

    // Byte address field positions
    localparam int OFF_LSB   = SPACE_OFFSET;
    localparam int OFF_MSB   = OFF_LSB + LINE_OFFSET_WIDTH - 1;
    localparam int IDX_LSB   = OFF_MSB + 1;
    localparam int IDX_MSB   = IDX_LSB + INDEX_WIDTH - 1;
    localparam int TAG_LSB   = IDX_MSB + 1;
    localparam int TAG_MSB   = ADDR_WIDTH - 1;
    localparam int LINE_LSBS = LINE_OFFSET_WIDTH + SPACE_OFFSET;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } cache_state_e;

    // Line-aligned byte address built from a tag and an index
    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0]       tag,
                                                        input logic [INDEX_WIDTH-1:0] idx);
        return {tag, idx, {LINE_LSBS{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag / valid / dirty / data storage for the direct-mapped D-cache.
// One combinational read port, a word-write port (store hit, marks dirty),
// a line-write port (refill, marks valid and clean) and a dirty-clear port
// (writeback done). Valid and dirty reset; tags and data do not.
module dcache_line_array
    import cache_pkg::*;
(
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [INDEX_WIDTH-1:0]       rd_idx_i,
    output logic                         rd_valid_o,
    output logic                         rd_dirty_o,
    output logic [TAG_W-1:0]             rd_tag_o,
    output logic [LINE_W-1:0]            rd_line_o,
    input  logic                         ww_en_i,
    input  logic [INDEX_WIDTH-1:0]       ww_idx_i,
    input  logic [LINE_OFFSET_WIDTH-1:0] ww_off_i,
    input  logic [WORD_W-1:0]            ww_data_i,
    input  logic                         lw_en_i,
    input  logic [INDEX_WIDTH-1:0]       lw_idx_i,
    input  logic [TAG_W-1:0]             lw_tag_i,
    input  logic [LINE_W-1:0]            lw_line_i,
    input  logic                         cl_en_i,
    input  logic [INDEX_WIDTH-1:0]       cl_idx_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];

    // Valid/dirty bookkeeping; a refill always leaves the line clean
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (lw_en_i) begin
                valid_q[lw_idx_i] <= 1'b1;
                dirty_q[lw_idx_i] <= 1'b0;
            end
            if (ww_en_i) begin
                dirty_q[ww_idx_i] <= 1'b1;
            end
            if (cl_en_i) begin
                dirty_q[cl_idx_i] <= 1'b0;
            end
        end
    end

    // Tag capture on refill
    always_ff @(posedge clk) begin
        if (lw_en_i) begin
            tag_q[lw_idx_i] <= lw_tag_i;
        end
    end

    // Line data: whole-line refill or single-word store (never in the same cycle)
    always_ff @(posedge clk) begin
        if (lw_en_i) begin
            data_q[lw_idx_i] <= lw_line_i;
        end else if (ww_en_i) begin
            data_q[ww_idx_i][ww_off_i*WORD_W +: WORD_W] <= ww_data_i;
        end
    end

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally in IDLE; misses run an optional WRITEBACK of a
// dirty victim followed by a REFILL over the mem_r/mem_w/mem_ready interface.
// Optional hit/miss statistics are built when CACHE_STATS_EN is defined.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | serve hits; a miss latches the request and starts the fill
//  WRITEBACK | dirty victim line driven out with mem_w until mem_ready
//  REFILL    | requested line fetched with mem_r; captured on mem_ready
module dcache_wb_ctrl
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_W-1:0]     cpu_wdata,
    output logic [WORD_W-1:0]     cpu_rdata,
    output logic                  cpu_ready,
    output logic                  mem_r,
    output logic                  mem_w,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_W-1:0]     mem_w_data,
    input  logic [LINE_W-1:0]     mem_r_data,
    input  logic                  mem_ready,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);

    cache_state_e                 state_q;
    logic [TAG_W-1:0]             req_tag_q;
    logic [INDEX_WIDTH-1:0]       req_idx_q;
    logic [LINE_OFFSET_WIDTH-1:0] req_off_q;
    logic                         req_we_q;
    logic [WORD_W-1:0]            req_wdata_q;
    logic                         refill_done_q;

    logic [TAG_W-1:0]             eff_tag;
    logic [INDEX_WIDTH-1:0]       eff_idx;
    logic [LINE_OFFSET_WIDTH-1:0] eff_off;
    logic                         eff_we;
    logic [WORD_W-1:0]            eff_wdata;

    logic [INDEX_WIDTH-1:0]       rd_idx;
    logic                         rd_valid;
    logic                         rd_dirty;
    logic [TAG_W-1:0]             rd_tag;
    logic [LINE_W-1:0]            rd_line;

    logic                         in_idle;
    logic                         hit;
    logic                         idle_hit;
    logic                         idle_miss;

    // Byte-in-word bits carry no meaning for word accesses
    logic unused_byte_bits;
    assign unused_byte_bits = ^cpu_addr[SPACE_OFFSET-1:0];

    // The first IDLE cycle after a refill completes the stalled request from the
    // latched copy, so CPU-side changes made during the stall cannot redirect it.
    assign eff_tag   = refill_done_q ? req_tag_q   : cpu_addr[TAG_MSB:TAG_LSB];
    assign eff_idx   = refill_done_q ? req_idx_q   : cpu_addr[IDX_MSB:IDX_LSB];
    assign eff_off   = refill_done_q ? req_off_q   : cpu_addr[OFF_MSB:OFF_LSB];
    assign eff_we    = refill_done_q ? req_we_q    : cpu_we;
    assign eff_wdata = refill_done_q ? req_wdata_q : cpu_wdata;

    assign in_idle   = (state_q == IDLE);
    assign rd_idx    = in_idle ? eff_idx : req_idx_q;
    assign hit       = rd_valid && (rd_tag == eff_tag);
    assign idle_hit  = in_idle && cpu_req && hit;
    assign idle_miss = in_idle && cpu_req && !hit;

    assign cpu_ready  = idle_hit;
    assign cpu_rdata  = rd_line[eff_off*WORD_W +: WORD_W];
    assign mem_w      = (state_q == WRITEBACK) && !mem_ready;
    assign mem_r      = (state_q == REFILL) && !mem_ready;
    assign mem_w_data = rd_line;

    // Memory-side line address: victim during writeback, requested line otherwise
    always_comb begin
        mem_addr = line_addr(eff_tag, eff_idx);
        case (state_q)
            WRITEBACK: mem_addr = line_addr(rd_tag, req_idx_q);
            REFILL:    mem_addr = line_addr(req_tag_q, req_idx_q);
            default:   mem_addr = line_addr(eff_tag, eff_idx);
        endcase
    end

    dcache_line_array u_lines (
        .clk        (clk),
        .rstn       (rstn),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .ww_en_i    (idle_hit && eff_we),
        .ww_idx_i   (eff_idx),
        .ww_off_i   (eff_off),
        .ww_data_i  (eff_wdata),
        .lw_en_i    ((state_q == REFILL) && mem_ready),
        .lw_idx_i   (req_idx_q),
        .lw_tag_i   (req_tag_q),
        .lw_line_i  (mem_r_data),
        .cl_en_i    ((state_q == WRITEBACK) && mem_ready),
        .cl_idx_i   (req_idx_q)
    );

    // Miss-handling FSM and request latch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            req_tag_q     <= '0;
            req_idx_q     <= '0;
            req_off_q     <= '0;
            req_we_q      <= 1'b0;
            req_wdata_q   <= '0;
            refill_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    refill_done_q <= 1'b0;
                    if (idle_miss) begin
                        req_tag_q   <= eff_tag;
                        req_idx_q   <= eff_idx;
                        req_off_q   <= eff_off;
                        req_we_q    <= eff_we;
                        req_wdata_q <= eff_wdata;
                        state_q     <= (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state_q <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        state_q       <= IDLE;
                        refill_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Statistics: the hit that closes a refill is not counted as a hit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle_hit && !refill_done_q) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (idle_miss) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Self-checking bench for dcache_wb_ctrl: directed access table plus
// hand-written sequences for the request latch and reset during a refill.
// Memory model: a request is counted for 5 cycles, mem_ready pulses on the
// next cycle, and the cycle after a pulse is a restart cycle in which a new
// request is not yet counted.
module tb_dcache_wb_ctrl;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         mem_r;
    logic         mem_w;
    logic [31:0]  mem_addr;
    logic [127:0] mem_w_data;
    logic [127:0] mem_r_data;
    logic         mem_ready;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dcache_wb_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_r      (mem_r),
        .mem_w      (mem_w),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data),
        .mem_ready  (mem_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    // ---------------- memory model ----------------
    function automatic logic [127:0] init_line(input logic [7:0] ln);
        case (ln)
            8'h04:   return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
            8'h24:   return 128'h24000003_24000002_24000001_24000000;
            8'h08:   return 128'h80000003_80000002_80000001_80000000;
            8'h00:   return 128'h00000F03_00000F02_00000F01_00000F00;
            default: return {8'h00, ln, 16'h0003, 8'h00, ln, 16'h0002,
                             8'h00, ln, 16'h0001, 8'h00, ln, 16'h0000};
        endcase
    endfunction

    logic [127:0] wr_mem [256];
    logic [255:0] wr_valid = '0;
    logic [2:0]   m_cnt;
    logic         m_cool;
    logic         m_wr;
    logic [31:0]  m_addr;
    logic [127:0] m_wdata;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_ready <= 1'b0;
            m_cnt     <= '0;
            m_cool    <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
        end else if (mem_ready) begin
            mem_ready <= 1'b0;
            m_cnt     <= '0;
            m_cool    <= 1'b1;
        end else if (m_cool) begin
            m_cool <= 1'b0;
        end else if (mem_r || mem_w) begin
            m_addr  <= mem_addr;
            m_wr    <= mem_w;
            m_wdata <= mem_w_data;
            if (m_cnt == 3'd4) mem_ready <= 1'b1;
            m_cnt <= m_cnt + 3'd1;
        end
    end

    always @(posedge clk) begin
        if (mem_ready && m_wr) begin
            wr_mem[m_addr[11:4]]   <= m_wdata;
            wr_valid[m_addr[11:4]] <= 1'b1;
        end
    end

    assign mem_r_data = !mem_ready ? 128'h0 :
                        (wr_valid[m_addr[11:4]] ? wr_mem[m_addr[11:4]] : init_line(m_addr[11:4]));

    // ---------------- bus monitor ----------------
    int           mon_w_cycles = 0;
    int           mon_r_cycles = 0;
    int           mon_both     = 0;
    logic [31:0]  mon_w_addr   = '0;
    logic [31:0]  mon_r_addr   = '0;
    logic [127:0] mon_w_data   = '0;

    always @(negedge clk) begin
        if (mem_w) begin
            mon_w_cycles <= mon_w_cycles + 1;
            mon_w_addr   <= mem_addr;
            mon_w_data   <= mem_w_data;
        end
        if (mem_r) begin
            mon_r_cycles <= mon_r_cycles + 1;
            mon_r_addr   <= mem_addr;
        end
        if (mem_r && mem_w) mon_both <= mon_both + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        @(posedge clk); #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        lat = 0;
        @(negedge clk);
        while (!cpu_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        rdata = cpu_rdata;
        chk({name, "_ready"}, 128'(cpu_ready), 128'(1'b1));
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic         chk_rd;
        logic [31:0]  exp_rdata;
        int           exp_lat;
        logic         exp_w;
        logic [31:0]  exp_waddr;
        logic [127:0] exp_wline;
        logic         exp_r;
        logic [31:0]  exp_raddr;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic chk_rd, input logic [31:0] exp_rdata, input int exp_lat,
                                input logic exp_w, input logic [31:0] exp_waddr,
                                input logic [127:0] exp_wline,
                                input logic exp_r, input logic [31:0] exp_raddr);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.chk_rd = chk_rd; v.exp_rdata = exp_rdata;
        v.exp_lat = exp_lat; v.exp_w = exp_w; v.exp_waddr = exp_waddr; v.exp_wline = exp_wline;
        v.exp_r = exp_r; v.exp_raddr = exp_raddr;
        return v;
    endfunction

    vec_t vecs[12];
    int   exp_hit;
    int   exp_miss;

    task automatic run_vec(input string name, input vec_t v);
        int          w0;
        int          r0;
        int          lat;
        logic [31:0] rd;
        w0 = mon_w_cycles;
        r0 = mon_r_cycles;
        access(name, v.we, v.addr, v.wdata, rd, lat);
        chk({name, "_latency"}, 128'(lat), 128'(v.exp_lat));
        if (v.chk_rd) chk({name, "_rdata"}, 128'(rd), 128'(v.exp_rdata));
        chk({name, "_mem_w_seen"}, 128'(mon_w_cycles != w0), 128'(v.exp_w));
        if (v.exp_w) begin
            chk({name, "_wb_addr"}, 128'(mon_w_addr), 128'(v.exp_waddr));
            chk({name, "_wb_data"}, mon_w_data, v.exp_wline);
        end
        chk({name, "_mem_r_seen"}, 128'(mon_r_cycles != r0), 128'(v.exp_r));
        if (v.exp_r) chk({name, "_refill_addr"}, 128'(mon_r_addr), 128'(v.exp_raddr));
        if (v.exp_lat == 0) exp_hit++;
        else exp_miss++;
        chk({name, "_hit_cnt"},  128'(hit_cnt),  STATS ? 128'(exp_hit)  : 128'h0);
        chk({name, "_miss_cnt"}, 128'(miss_cnt), STATS ? 128'(exp_miss) : 128'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        int          lat;
        int          cyc;

        //            we    addr          wdata         rd?   exp_rdata     lat  w?    waddr         wline                                         r?    raddr
        vecs[0]  = mk(1'b0, 32'h0000_0040, 32'h0,        1'b1, 32'hAAAA_AAAA, 7,  1'b0, 32'h0,        128'h0,                                       1'b1, 32'h0000_0040);
        vecs[1]  = mk(1'b0, 32'h0000_0044, 32'h0,        1'b1, 32'hBBBB_BBBB, 0,  1'b0, 32'h0,        128'h0,                                       1'b0, 32'h0);
        vecs[2]  = mk(1'b1, 32'h0000_0048, 32'h1234_5678, 1'b0, 32'h0,        0,  1'b0, 32'h0,        128'h0,                                       1'b0, 32'h0);
        vecs[3]  = mk(1'b0, 32'h0000_0048, 32'h0,        1'b1, 32'h1234_5678, 0,  1'b0, 32'h0,        128'h0,                                       1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 32'h0000_0240, 32'h0,        1'b1, 32'h2400_0000, 14, 1'b1, 32'h0000_0040, 128'hDDDDDDDD_12345678_BBBBBBBB_AAAAAAAA, 1'b1, 32'h0000_0240);
        vecs[5]  = mk(1'b1, 32'h0000_0084, 32'hCAFE_F00D, 1'b0, 32'h0,        7,  1'b0, 32'h0,        128'h0,                                       1'b1, 32'h0000_0080);
        vecs[6]  = mk(1'b0, 32'h0000_0084, 32'h0,        1'b1, 32'hCAFE_F00D, 0,  1'b0, 32'h0,        128'h0,                                       1'b0, 32'h0);
        vecs[7]  = mk(1'b0, 32'h0000_0048, 32'h0,        1'b1, 32'h1234_5678, 7,  1'b0, 32'h0,        128'h0,                                       1'b1, 32'h0000_0040);
        vecs[8]  = mk(1'b0, 32'h0000_0244, 32'h0,        1'b1, 32'h2400_0001, 7,  1'b0, 32'h0,        128'h0,                                       1'b1, 32'h0000_0240);
        vecs[9]  = mk(1'b0, 32'h0000_0008, 32'h0,        1'b1, 32'h0000_0F02, 14, 1'b1, 32'h0000_0080, 128'h80000003_80000002_CAFEF00D_80000000, 1'b1, 32'h0000_0000);
        vecs[10] = mk(1'b0, 32'h0000_000C, 32'h0,        1'b1, 32'h0000_0F03, 0,  1'b0, 32'h0,        128'h0,                                       1'b0, 32'h0);
        vecs[11] = mk(1'b0, 32'h0000_004C, 32'h0,        1'b1, 32'hDDDD_DDDD, 7,  1'b0, 32'h0,        128'h0,                                       1'b1, 32'h0000_0040);

        rstn      = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        exp_hit   = 0;
        exp_miss  = 0;

        repeat (3) @(negedge clk);
        chk("reset_cpu_ready", 128'(cpu_ready), 128'h0);
        chk("reset_mem_r",     128'(mem_r),     128'h0);
        chk("reset_mem_w",     128'(mem_w),     128'h0);
        chk("reset_hit_cnt",   128'(hit_cnt),   128'h0);
        chk("reset_miss_cnt",  128'(miss_cnt),  128'h0);

        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_noreq_ready", 128'(cpu_ready), 128'h0);
        chk("idle_noreq_mem",   128'({mem_r, mem_w}), 128'h0);

        foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

        // Request latch: address changes during the stall must not move the refill
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_01C0;
        @(negedge clk);
        @(negedge clk);
        chk("latch_mem_r", 128'(mem_r), 128'h1);
        cpu_addr = 32'h0000_0300;
        @(negedge clk);
        chk("latch_mem_addr", 128'(mem_addr), 128'h1C0);
        @(negedge clk);
        chk("latch_mem_addr2", 128'(mem_addr), 128'h1C0);
        cpu_addr = 32'h0000_01C0;
        cyc = 0;
        while (!cpu_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("latch_ready",  128'(cpu_ready), 128'h1);
        chk("latch_rdata",  128'(cpu_rdata), 128'h001C_0000);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        exp_miss++;
        chk("latch_miss_cnt", 128'(miss_cnt), STATS ? 128'(exp_miss) : 128'h0);

        // Reset in the middle of a refill
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0280;
        repeat (3) @(negedge clk);
        chk("rst_pre_mem_r", 128'(mem_r), 128'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_async_mem_r",   128'(mem_r),     128'h0);
        chk("rst_async_mem_w",   128'(mem_w),     128'h0);
        chk("rst_async_ready",   128'(cpu_ready), 128'h0);
        chk("rst_async_hit",     128'(hit_cnt),   128'h0);
        chk("rst_async_miss",    128'(miss_cnt),  128'h0);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_hit  = 0;
        exp_miss = 0;

        run_vec("post_rst_0C", mk(1'b0, 32'h0000_000C, 32'h0, 1'b1, 32'h0000_0F03, 7, 1'b0, 32'h0, 128'h0, 1'b1, 32'h0000_0000));
        run_vec("post_rst_40", mk(1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'hAAAA_AAAA, 7, 1'b0, 32'h0, 128'h0, 1'b1, 32'h0000_0040));
        run_vec("post_rst_44", mk(1'b0, 32'h0000_0044, 32'h0, 1'b1, 32'hBBBB_BBBB, 0, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0));

        access("post_rst_48", 1'b0, 32'h0000_0048, 32'h0, rd, lat);
        chk("post_rst_48_rdata", 128'(rd), 128'h1234_5678);

        chk("mem_r_and_mem_w_never_together", 128'(mon_both), 128'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
